// File: rtl/switch_pkg.sv
// Shared switch types: packet layout, header slicing and arbiter FSM states.
package switch_pkg;

   localparam int unsigned PKT_SIZE  = 16;
   localparam int unsigned NUM_PORTS = 4;
   localparam int unsigned HDR_W     = 8;
   localparam int unsigned IDX_W     = $clog2(NUM_PORTS);
   localparam int unsigned PORT_W    = 4;
   localparam int unsigned CNT_W     = 16;

   // Packet field positions
   localparam int unsigned SRC_MSB  = 15;
   localparam int unsigned SRC_LSB  = 12;
   localparam int unsigned TGT_MSB  = 11;
   localparam int unsigned TGT_LSB  = 8;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned DATA_LSB = 0;

   // Header is the packet's upper byte: {source, target}
   localparam int unsigned HDR_TGT_LSB = TGT_LSB - TGT_LSB;

   typedef struct packed {
      logic [SRC_MSB-SRC_LSB:0]   src;
      logic [TGT_MSB-TGT_LSB:0]   tgt;
      logic [DATA_MSB-DATA_LSB:0] data;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } arb_state_t;

   // Target port number carried in a head header
   function automatic logic [PORT_W-1:0] hdr_target(input logic [HDR_W-1:0] hdr);
      return hdr[HDR_TGT_LSB +: PORT_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesting inputs, starting after the last grant.
module rr_arbiter
   import switch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic                 i_update,
   output logic [IDX_W-1:0]     o_grant_c,
   output logic                 o_grant_valid_c
);

   logic [IDX_W-1:0] r_last_grant;
   logic [IDX_W-1:0] w_cand;

   // Last-grant pointer; reset value gives port 0 first priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= IDX_W'(NUM_PORTS - 1);
      end else if (i_update) begin
         r_last_grant <= o_grant_c;
      end
   end

   // Search from last_grant+1 and take the first requester found
   always_comb begin
      o_grant_c       = '0;
      o_grant_valid_c = 1'b0;
      w_cand          = '0;
      for (int k = 1; k <= int'(NUM_PORTS); k++) begin
         w_cand = IDX_W'((int'(r_last_grant) + k) % int'(NUM_PORTS));
         if (!o_grant_valid_c && i_req[w_cand]) begin
            o_grant_c       = w_cand;
            o_grant_valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port reader: arbitrates input FIFO heads aimed at this port,
// pops one packet at a time and holds it on a valid/ready output.
module output_port_arbiter
   import switch_pkg::*;
#(
   parameter int unsigned PORT_ID = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          fifo_empty,
   input  logic [NUM_PORTS*HDR_W-1:0]    fifo_header,
   input  logic [NUM_PORTS*PKT_SIZE-1:0] fifo_data,
   output logic [NUM_PORTS-1:0]          fifo_rd_en,
   output logic [PKT_SIZE-1:0]           out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              pkt_count
);

   arb_state_t           r_state;
   logic [IDX_W-1:0]     r_grant;
   logic [NUM_PORTS-1:0] r_rd_en;
   pkt_t                 r_out_data;
   logic                 r_out_valid;
   logic [CNT_W-1:0]     r_pkt_count;

   logic [NUM_PORTS-1:0] w_req;
   logic [IDX_W-1:0]     w_grant;
   logic                 w_grant_valid;
   logic                 w_update;
   logic                 w_hdr_unused;

   // Source nibbles of the headers are not needed for arbitration
   assign w_hdr_unused = ^fifo_header;

   // A FIFO requests when non-empty and its head targets this port
   always_comb begin
      w_req = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         w_req[i] = !fifo_empty[i] &&
                    (hdr_target(fifo_header[i*HDR_W +: HDR_W]) == PORT_W'(PORT_ID));
      end
   end

   assign w_update = (r_state == IDLE) && w_grant_valid;

   rr_arbiter u_rr_arbiter (
      .clk             (clk),
      .rst             (rst),
      .i_req           (w_req),
      .i_update        (w_update),
      .o_grant_c       (w_grant),
      .o_grant_valid_c (w_grant_valid)
   );

   // Packet FSM: grant, single-cycle pop, capture read data, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_rd_en     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         r_rd_en <= '0;
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_grant          <= w_grant;
                  r_rd_en[w_grant] <= 1'b1;
                  r_state          <= READ;
               end
            end
            READ: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               r_out_data  <= pkt_t'(fifo_data[32'(r_grant)*PKT_SIZE +: PKT_SIZE]);
               r_out_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pkt_count <= r_pkt_count + CNT_W'(1);
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fifo_rd_en = r_rd_en;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign pkt_count  = r_pkt_count;

endmodule
